// File: rtl/cordic_iter_engine.sv
// Iterative handshaked CORDIC engine (rotation/vectoring) with full-range angle reduction.
// Define CORDIC_GAIN_COMP_EN to add a SCALE state that removes the CORDIC gain from x and y.
module cordic_iter_engine #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 27,
  parameter int unsigned ITER  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned LutN = 2 ** CntW;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StReduce  = 3'd1;
  localparam logic [2:0] StFold    = 3'd2;
  localparam logic [2:0] StIterate = 3'd3;
  localparam logic [2:0] StDone    = 3'd5;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [2:0] StScale   = 3'd4;
`endif

  // pi * 2^61, the source for every angle constant.
  localparam logic [63:0] Pi2p61 = 64'h6487ED5110B4611A;

  function automatic logic [63:0] rnd_shr(input logic [63:0] v, input int unsigned sh);
    rnd_shr = (v + (64'd1 << (sh - 1))) >> sh;
  endfunction

  // atan(2^-i) with 62 fractional bits; alternating series for i >= 1.
  function automatic logic [63:0] atan_2p62(input int unsigned i);
    logic [63:0]  acc;
    int unsigned  sh;
    acc = '0;
    if (i == 0) begin
      acc = Pi2p61 >> 1;
    end else begin
      for (int unsigned k = 0; k < 32; k++) begin
        sh = i * (2 * k + 1);
        if (sh < 63) begin
          if (k[0]) acc = acc - ((64'h4000_0000_0000_0000 >> sh) / 64'(2 * k + 1));
          else      acc = acc + ((64'h4000_0000_0000_0000 >> sh) / 64'(2 * k + 1));
        end
      end
    end
    atan_2p62 = acc;
  endfunction

  localparam logic signed [WIDTH-1:0] PI_Q        = WIDTH'(rnd_shr(Pi2p61, 61 - FRAC));
  localparam logic signed [WIDTH-1:0] HALF_PI_Q   = WIDTH'(rnd_shr(Pi2p61, 62 - FRAC));
  localparam logic signed [WIDTH-1:0] TWO_PI_Q    = WIDTH'(rnd_shr(Pi2p61, 60 - FRAC));
  localparam logic signed [WIDTH-1:0] NEG_PI_Q    = -PI_Q;
  localparam logic signed [WIDTH-1:0] NEG_HALF_PI = -HALF_PI_Q;

  logic signed [WIDTH-1:0] atan_lut [LutN];
  for (genvar g = 0; g < LutN; g++) begin : g_atan
    localparam logic [WIDTH-1:0] AtanG =
        (g < ITER) ? WIDTH'(rnd_shr(atan_2p62(g), 62 - FRAC)) : '0;
    assign atan_lut[g] = AtanG;
  end

  logic [2:0]              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [WIDTH-1:0] xs, ys, atan_i;
  logic                    d_pos;

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [WIDTH-1:0] K_Q = WIDTH'($rtoi(0.607252935 * (2.0 ** FRAC) + 0.5));
  logic signed [2*WIDTH-1:0] prod_x, prod_y;
  assign prod_x = x_q * K_Q;
  assign prod_y = y_q * K_Q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xs      = x_q >>> cnt_q;
    ys      = y_q >>> cnt_q;
    atan_i  = atan_lut[cnt_q];
    // Rotation steers z to 0, vectoring steers y to 0.
    d_pos   = mode_q ? y_q[WIDTH-1] : ~z_q[WIDTH-1];
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = mode ? '0 : z_in;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = StReduce;
        end
      end
      StReduce: begin
        if (!mode_q) begin
          if (z_q > PI_Q)          z_d = z_q - TWO_PI_Q;
          else if (z_q < NEG_PI_Q) z_d = z_q + TWO_PI_Q;
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(2)) begin
          cnt_d   = '0;
          state_d = StFold;
        end
      end
      StFold: begin
        if (!mode_q) begin
          if (z_q > HALF_PI_Q) begin
            z_d = z_q - PI_Q;
            x_d = -x_q;
            y_d = -y_q;
          end else if (z_q < NEG_HALF_PI) begin
            z_d = z_q + PI_Q;
            x_d = -x_q;
            y_d = -y_q;
          end
        end else if (x_q[WIDTH-1]) begin
          x_d = -x_q;
          y_d = -y_q;
          z_d = y_q[WIDTH-1] ? NEG_PI_Q : PI_Q;
        end
        cnt_d   = '0;
        state_d = StIterate;
      end
      StIterate: begin
        if (d_pos) begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + atan_i;
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ITER - 1)) begin
          cnt_d = '0;
`ifdef CORDIC_GAIN_COMP_EN
          state_d = StScale;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      StScale: begin
        x_d     = prod_x[FRAC +: WIDTH];
        y_d     = prod_y[FRAC +: WIDTH];
        state_d = StDone;
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;

endmodule
